// File: rtl/prog_delay_line.sv
// prog_delay_line: a delay line with programmable depth. It uses a circular
// buffer and only advances when a sample is accepted. Each accepted sample
// comes out exactly D accepts later. D is loaded at run time (1..MAX_DEPTH).
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active-high
//   cfg_load_i    1-cycle strobe: latch cfg_depth_i and restart filling
//   cfg_depth_i   requested delay D, in accepts
//   flush_i       discard buffered samples, keep current D
//   in_valid_i    sample accept strobe (shift enable)
//   in_data_i     sample in
//   out_valid_o   out_data_o is valid this cycle (registered)
//   out_data_o    delayed sample
//   filled_o      buffer holds D samples (RUN state)
//   fill_count_o  samples buffered while filling; equals D once running
//   depth_err_o   1-cycle pulse after a cfg_load_i with an illegal depth
//
// States
//   IDLE | no depth loaded, input ignored
//   FILL | collecting the first D samples after a load or flush
//   RUN  | every accept emits the sample written D accepts ago
module prog_delay_line #(
    parameter int WIDTH     = 8,
    parameter int MAX_DEPTH = 256,
    parameter int ZERO_FILL = 0,
    localparam int AW       = $clog2(MAX_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load_i,
    input  logic [AW-1:0]    cfg_depth_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             filled_o,
    output logic [AW-1:0]    fill_count_o,
    output logic             depth_err_o
);
    localparam int PW = $clog2(MAX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    depth_q, depth_d;
    logic [PW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    fill_q, fill_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             depth_err_q, depth_err_d;
    logic             mem_we;
    logic [WIDTH-1:0] rd_data;
    logic             depth_legal;
    logic             accept;
    logic [AW-1:0]    fill_inc;

    // The buffer is deliberately left unreset. Nothing is read from it until
    // every slot in the active depth has been written since the last restart.
    logic [WIDTH-1:0] mem [MAX_DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wp_q] <= in_data_i;
        end
    end

    // The read is combinational from the pre-edge contents. On the accept edge
    // the output register therefore takes the old word at wp_q, and the new
    // sample overwrites that slot.
    assign rd_data     = mem[wp_q];
    assign depth_legal = (cfg_depth_i != '0) && (cfg_depth_i <= AW'(MAX_DEPTH));
    assign accept      = in_valid_i && !cfg_load_i && !flush_i && (state_q != S_IDLE);
    assign fill_inc    = fill_q + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            depth_q     <= '0;
            wp_q        <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            depth_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            wp_q        <= wp_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            depth_err_q <= depth_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        wp_d        = wp_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        depth_err_d = 1'b0;
        mem_we      = 1'b0;

        if (cfg_load_i) begin
            if (depth_legal) begin
                depth_d = cfg_depth_i;
                wp_d    = '0;
                fill_d  = '0;
                state_d = S_FILL;
            end else begin
                depth_err_d = 1'b1;
            end
        end else if (flush_i && (state_q != S_IDLE)) begin
            wp_d    = '0;
            fill_d  = '0;
            state_d = S_FILL;
        end else if (accept) begin
            mem_we = 1'b1;
            // wp wraps at the loaded depth, not at the buffer size.
            wp_d = ({1'b0, wp_q} == depth_q - AW'(1)) ? '0 : wp_q + PW'(1);
            if (state_q == S_FILL) begin
                fill_d = fill_inc;
                if (fill_inc == depth_q) begin
                    state_d = S_RUN;
                end
                if (ZERO_FILL != 0) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                end
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = rd_data;
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign filled_o     = (state_q == S_RUN);
    assign fill_count_o = fill_q;
    assign depth_err_o  = depth_err_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line. Two instances share the stimulus:
// dut0 has ZERO_FILL=0 and dut1 has ZERO_FILL=1. A reference model keeps a
// history of accepted samples. For every driven cycle it queues the expected
// outputs, and the queue is popped one cycle later when the DUTs respond.
// A small table of hand-computed vectors covers the basic D=3 sequence.
module tb_prog_delay_line;
    localparam int MAXD = 16;
    localparam int AW   = $clog2(MAXD) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_load;
    logic [AW-1:0] cfg_depth;
    logic          flush;
    logic          in_valid;
    logic [7:0]    in_data;

    logic          ov0, ov1, f0, f1, de0, de1;
    logic [7:0]    od0, od1;
    logic [AW-1:0] fc0, fc1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    prog_delay_line #(.WIDTH(8), .MAX_DEPTH(MAXD), .ZERO_FILL(0)) dut0 (
        .clk(clk), .rst(rst), .cfg_load_i(cfg_load), .cfg_depth_i(cfg_depth),
        .flush_i(flush), .in_valid_i(in_valid), .in_data_i(in_data),
        .out_valid_o(ov0), .out_data_o(od0), .filled_o(f0),
        .fill_count_o(fc0), .depth_err_o(de0));

    prog_delay_line #(.WIDTH(8), .MAX_DEPTH(MAXD), .ZERO_FILL(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_load_i(cfg_load), .cfg_depth_i(cfg_depth),
        .flush_i(flush), .in_valid_i(in_valid), .in_data_i(in_data),
        .out_valid_o(ov1), .out_data_o(od1), .filled_o(f1),
        .fill_count_o(fc1), .depth_err_o(de1));

    typedef struct {
        logic          ov0;
        logic          ov1;
        logic [7:0]    od0;
        logic [7:0]    od1;
        logic          filled;
        logic [AW-1:0] fc;
        logic          err;
    } exp_t;

    typedef struct {
        logic          cl;
        logic [AW-1:0] d;
        logic          iv;
        logic [7:0]    di;
        logic          e_ov;
        logic          e_chkd;
        logic [7:0]    e_od;
        logic          e_filled;
        logic [AW-1:0] e_fc;
    } vec_t;

    exp_t       sb[$];
    logic [7:0] hist[$];
    logic [7:0] cap[$];
    int         m_active = 0;
    int         m_depth  = 0;
    int         m_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_active = 0;
        m_depth  = 0;
        m_cnt    = 0;
        hist.delete();
    endtask

    // Drive one cycle, queue the model's expectation, then compare after the edge.
    task automatic step(input logic cl, input logic [AW-1:0] d, input logic fl,
                        input logic iv, input logic [7:0] di);
        exp_t e;
        cfg_load = cl; cfg_depth = d; flush = fl; in_valid = iv; in_data = di;
        e.ov0 = 1'b0; e.ov1 = 1'b0; e.od0 = 8'h00; e.od1 = 8'h00; e.err = 1'b0;
        if (rst) begin
            model_reset();
        end else if (cl) begin
            if (d >= 1 && d <= MAXD) begin
                m_depth = int'(d); m_cnt = 0; m_active = 1; hist.delete();
            end else begin
                e.err = 1'b1;
            end
        end else if (fl && m_active != 0) begin
            m_cnt = 0; hist.delete();
        end else if (iv && m_active != 0) begin
            if (m_cnt < m_depth) begin
                m_cnt++;
                e.ov1 = 1'b1;
            end else begin
                e.ov0 = 1'b1; e.ov1 = 1'b1;
                e.od0 = hist[hist.size() - m_depth];
                e.od1 = e.od0;
            end
            hist.push_back(di);
            if (hist.size() > MAXD) void'(hist.pop_front());
        end
        e.filled = (m_active != 0) && (m_cnt == m_depth);
        e.fc     = AW'(m_cnt);
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out_valid0", 32'(ov0), 32'(e.ov0));
        check("out_valid1", 32'(ov1), 32'(e.ov1));
        if (e.ov0) check("out_data0", 32'(od0), 32'(e.od0));
        if (e.ov1) check("out_data1", 32'(od1), 32'(e.od1));
        check("filled", 32'(f0), 32'(e.filled));
        check("filled1", 32'(f1), 32'(e.filled));
        check("fill_count", 32'(fc0), 32'(e.fc));
        check("depth_err0", 32'(de0), 32'(e.err));
        check("depth_err1", 32'(de1), 32'(e.err));
        if (ov0) cap.push_back(od0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 8'h00);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, AW'(3), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, AW'(0)};
        tbl[1] = '{1'b0, AW'(0), 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, AW'(1)};
        tbl[2] = '{1'b0, AW'(0), 1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, AW'(2)};
        tbl[3] = '{1'b0, AW'(0), 1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b1, AW'(3)};
        tbl[4] = '{1'b0, AW'(0), 1'b1, 8'h04, 1'b1, 1'b1, 8'h01, 1'b1, AW'(3)};
        tbl[5] = '{1'b0, AW'(0), 1'b1, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, AW'(3)};
        tbl[6] = '{1'b0, AW'(0), 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b1, AW'(3)};
        tbl[7] = '{1'b0, AW'(0), 1'b1, 8'h06, 1'b1, 1'b1, 8'h03, 1'b1, AW'(3)};

        rst = 1'b1; cfg_load = 0; cfg_depth = '0; flush = 0; in_valid = 0; in_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(ov0), 0);
        check("rst_out_data", 32'(od0), 0);
        check("rst_filled", 32'(f0), 0);
        check("rst_fill_count", 32'(fc0), 0);
        check("rst_depth_err", 32'(de0), 0);
        rst = 1'b0;
        model_reset();

        // Idle state ignores samples and flushes.
        step(1'b0, '0, 1'b0, 1'b1, 8'h55);
        step(1'b0, '0, 1'b1, 1'b1, 8'h66);

        // D=3, back-to-back, hand-computed expectations for dut0.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].cl, tbl[i].d, 1'b0, tbl[i].iv, tbl[i].di);
            check($sformatf("tbl%0d_out_valid", i), 32'(ov0), 32'(tbl[i].e_ov));
            if (tbl[i].e_chkd) check($sformatf("tbl%0d_out_data", i), 32'(od0), 32'(tbl[i].e_od));
            check($sformatf("tbl%0d_filled", i), 32'(f0), 32'(tbl[i].e_filled));
            check($sformatf("tbl%0d_fill_count", i), 32'(fc0), 32'(tbl[i].e_fc));
        end

        // D=3 with random gaps: same data sequence, valid only after accepts.
        step(1'b1, AW'(3), 1'b0, 1'b0, 8'h00);
        cap.delete();
        for (int v = 1; v <= 8; v++) begin
            idle($urandom_range(0, 3));
            step(1'b0, '0, 1'b0, 1'b1, 8'(v));
        end
        idle(2);
        check("gap_beats", cap.size(), 5);
        for (int i = 0; i < 5 && i < cap.size(); i++)
            check($sformatf("gap_data%0d", i), 32'(cap[i]), 32'(i + 1));

        // Illegal depths in RUN: error pulse, stream unaffected.
        step(1'b1, AW'(0), 1'b0, 1'b0, 8'h00);
        step(1'b0, '0, 1'b0, 1'b1, 8'h09);
        step(1'b1, AW'(MAXD + 1), 1'b0, 1'b0, 8'h00);
        idle(1);
        step(1'b0, '0, 1'b0, 1'b1, 8'h0A);

        // Async reset mid-RUN: outputs clear before any clock edge.
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(ov1), 0);
        check("arst_out_data", 32'(od0), 0);
        check("arst_filled", 32'(f0), 0);
        check("arst_fill_count", 32'(fc0), 0);
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, 1'b1, 8'h11);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 8'(8'h20 + i));

        // D=1 and D=MAX_DEPTH ramps across pointer wraps, with zero-fill on dut1.
        step(1'b1, AW'(1), 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3 * MAXD; i++) step(1'b0, '0, 1'b0, 1'b1, 8'(i + 1));
        step(1'b1, AW'(MAXD), 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3 * MAXD; i++) step(1'b0, '0, 1'b0, 1'b1, 8'(8'h80 + i));

        // Flush and cfg_load in RUN, each colliding with a sample.
        step(1'b0, '0, 1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, 8'(8'h40 + i));
        step(1'b1, AW'(4), 1'b0, 1'b1, 8'hDD);
        check("load_fill_count", 32'(fc0), 0);
        check("load_filled", 32'(f0), 0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, 8'(8'h60 + i));

        // Random mix of loads, flushes and gapped traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, AW'($urandom_range(0, MAXD + 2)),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
                 8'($urandom_range(0, 255)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
